// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared types, width helpers and parameter checks for fifo_stream_drain
package fifo_stream_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // One output beat as seen downstream: the word plus its burst-framing flag
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
  } beat_t;

  // Pointer width for a circular buffer; a single-entry buffer still gets one bit
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

  function automatic bit params_ok(input int skid_depth, input int rd_latency, input int burst_len);
    return (rd_latency >= 0) && (rd_latency <= 1) &&
           (skid_depth >= rd_latency + 1) && (burst_len >= 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - circular skid buffer; head entry is presented, push and pop may coincide at any occupancy
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int OCC_W      = 2
) (
  input  logic                  MCLK,
  input  logic                  nRST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - drains a FiFo through nRE/EMPTY/DOUT into a valid/ready stream with burst LAST framing
module fifo_stream_drain
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic                  MCLK,
  input  logic                  nRST,
  input  logic                  EN,
  output logic                  nRE,
  input  logic [DATA_WIDTH-1:0] FIFO_DIN,
  input  logic                  EMPTY,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_LAST,
  output logic                  BUSY
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;
  localparam int CNT_W = cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  if (!params_ok(SKID_DEPTH, RD_LATENCY, BURST_LEN)) begin : g_param_err
    $error("fifo_stream_drain: illegal SKID_DEPTH/RD_LATENCY/BURST_LEN combination");
  end

  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;
  logic             infl;
  logic             infl_nxt;
  logic [SUM_W-1:0] credit;
  logic             beat;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] cnt;

  assign beat = M_VALID & M_READY;

  // The beat leaving this cycle frees a slot, which is what keeps one word per cycle at depth 2
  assign credit = SUM_W'(occ) + SUM_W'(infl) - SUM_W'(beat);
  assign pop    = EN & ~EMPTY & (credit < SUM_W'(SKID_DEPTH));
  assign nRE    = ~pop;

  if (RD_LATENCY == 0) begin : g_fwft
    assign push     = pop;
    assign infl_nxt = 1'b0;
  end else begin : g_lat1
    assign push     = infl;
    assign infl_nxt = pop;
  end

  assign occ_nxt = occ + OCC_W'(push) - OCC_W'(beat);

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH),
    .OCC_W      (OCC_W)
  ) u_buf (
    .MCLK      (MCLK),
    .nRST      (nRST),
    .push      (push),
    .push_data (FIFO_DIN),
    .pop       (beat),
    .occ       (occ),
    .head      (M_DATA)
  );

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      infl    <= 1'b0;
      M_VALID <= 1'b0;
      BUSY    <= 1'b0;
      cnt     <= '0;
    end else begin
      infl    <= infl_nxt;
      M_VALID <= (occ_nxt != '0);
      BUSY    <= (occ_nxt != '0) | infl_nxt;
      if (beat) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Qualified by M_VALID so the flag is low out of reset even when every beat is a last beat
  assign M_LAST = M_VALID & (cnt == CNT_LAST);

  always_ff @(posedge MCLK) begin
    if (nRST) begin
      assert (SUM_W'(occ) + SUM_W'(infl) <= SUM_W'(SKID_DEPTH));
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb/tb_fifo_stream_drain.sv - directed bench: two drain instances, each fed by a depth-2 FiFo model
module tb_fifo_stream_drain;

  logic        MCLK;
  logic        nRST;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        en_a, ready_a, nre_a, empty_a, valid_a, last_a, busy_a;
  logic [31:0] din_a, data_a;
  logic        en_b, ready_b, nre_b, empty_b, valid_b, last_b, busy_b;
  logic [31:0] din_b, data_b;

  fifo_stream_drain #(.DATA_WIDTH(32), .RD_LATENCY(1), .SKID_DEPTH(2), .BURST_LEN(4)) dut_a (
    .MCLK(MCLK), .nRST(nRST), .EN(en_a), .nRE(nre_a), .FIFO_DIN(din_a), .EMPTY(empty_a),
    .M_VALID(valid_a), .M_READY(ready_a), .M_DATA(data_a), .M_LAST(last_a), .BUSY(busy_a)
  );

  fifo_stream_drain #(.DATA_WIDTH(32), .RD_LATENCY(0), .SKID_DEPTH(2), .BURST_LEN(1)) dut_b (
    .MCLK(MCLK), .nRST(nRST), .EN(en_b), .nRE(nre_b), .FIFO_DIN(din_b), .EMPTY(empty_b),
    .M_VALID(valid_b), .M_READY(ready_b), .M_DATA(data_b), .M_LAST(last_b), .BUSY(busy_b)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc++;

  // FiFo models, DEPTH=2: A has one-cycle read latency, B is fall-through
  logic        wr_a, wr_b, full_a, full_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] fa_mem [2];
  logic [31:0] fb_mem [2];
  logic        fa_wp, fa_rp, fb_wp, fb_rp, fa_pop, fa_push, fb_pop, fb_push;
  logic [1:0]  fa_cnt, fb_cnt;

  assign fa_pop  = !nre_a && (fa_cnt != 2'd0);
  assign fa_push = wr_a && (fa_cnt != 2'd2);
  assign empty_a = (fa_cnt == 2'd0);
  assign full_a  = (fa_cnt == 2'd2);
  assign fb_pop  = !nre_b && (fb_cnt != 2'd0);
  assign fb_push = wr_b && (fb_cnt != 2'd2);
  assign empty_b = (fb_cnt == 2'd0);
  assign full_b  = (fb_cnt == 2'd2);
  assign din_b   = fb_mem[fb_rp];

  always @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      fa_wp <= 1'b0; fa_rp <= 1'b0; fa_cnt <= 2'd0; din_a <= '0;
      fb_wp <= 1'b0; fb_rp <= 1'b0; fb_cnt <= 2'd0;
    end else begin
      if (fa_push) begin fa_mem[fa_wp] <= wdata_a; fa_wp <= ~fa_wp; end
      if (fa_pop)  begin din_a <= fa_mem[fa_rp]; fa_rp <= ~fa_rp; end
      fa_cnt <= fa_cnt + {1'b0, fa_push} - {1'b0, fa_pop};
      if (fb_push) begin fb_mem[fb_wp] <= wdata_b; fb_wp <= ~fb_wp; end
      if (fb_pop)  fb_rp <= ~fb_rp;
      fb_cnt <= fb_cnt + {1'b0, fb_push} - {1'b0, fb_pop};
    end
  end

  // Feeders: push incrementing words while room remains
  int feed_a = 0, feed_b = 0;
  int next_a = 0, next_b = 0;
  initial begin wr_a = 1'b0; wr_b = 1'b0; wdata_a = '0; wdata_b = '0; end
  always begin
    @(posedge MCLK); #1;
    if (feed_a > 0 && !full_a && nRST) begin
      wr_a = 1'b1; wdata_a = next_a; next_a++; feed_a--;
    end else wr_a = 1'b0;
    if (feed_b > 0 && !full_b && nRST) begin
      wr_b = 1'b1; wdata_b = next_b; next_b++; feed_b--;
    end else wr_b = 1'b0;
  end

  // Beat monitors, sampled mid-cycle
  logic [31:0] bd_a[$], bd_b[$];
  logic        bl_a[$], bl_b[$], bbusy_a[$];
  int          bc_a[$];
  int          pops_a = 0, pops_b = 0;
  int          first_pop_a = -1, first_vld_a = -1, first_pop_b = -1, first_vld_b = -1;
  bit          ovf_a = 1'b0;

  always @(negedge MCLK) begin
    if (!nRST) begin
      bd_a.delete(); bl_a.delete(); bc_a.delete(); bbusy_a.delete();
      bd_b.delete(); bl_b.delete();
      pops_a = 0; pops_b = 0; ovf_a = 1'b0;
      first_pop_a = -1; first_vld_a = -1; first_pop_b = -1; first_vld_b = -1;
    end else begin
      if (pops_a - bd_a.size() > 2) ovf_a = 1'b1;
      if (!nre_a) begin if (first_pop_a < 0) first_pop_a = cyc; pops_a++; end
      if (valid_a && first_vld_a < 0) first_vld_a = cyc;
      if (valid_a && ready_a) begin
        bd_a.push_back(data_a); bl_a.push_back(last_a); bc_a.push_back(cyc); bbusy_a.push_back(busy_a);
      end
      if (!nre_b) begin if (first_pop_b < 0) first_pop_b = cyc; pops_b++; end
      if (valid_b && first_vld_b < 0) first_vld_b = cyc;
      if (valid_b && ready_b) begin bd_b.push_back(data_b); bl_b.push_back(last_b); end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge MCLK); #1; end
  endtask

  task automatic do_reset;
    nRST = 1'b0; en_a = 1'b0; ready_a = 1'b0; en_b = 1'b0; ready_b = 1'b0;
    feed_a = 0; feed_b = 0;
    step(2);
    nRST = 1'b1;
    step(1);
  endtask

  task automatic wait_beats_a(input int n, input int budget, input bit toggle);
    int k = 0;
    while (bd_a.size() < n && k < budget) begin
      step(1); k++;
      if (toggle) ready_a = ~ready_a;
    end
    checks++;
    if (bd_a.size() < n) begin
      errors++; $display("FAIL wait_beats_a: got %0d beats, required %0d", bd_a.size(), n);
    end
  endtask

  task automatic wait_beats_b(input int n, input int budget);
    int k = 0;
    while (bd_b.size() < n && k < budget) begin step(1); k++; end
    checks++;
    if (bd_b.size() < n) begin
      errors++; $display("FAIL wait_beats_b: got %0d beats, required %0d", bd_b.size(), n);
    end
  endtask

  task automatic test_reset;
    nRST = 1'b1; en_a = 1'b0; ready_a = 1'b0; en_b = 1'b0; ready_b = 1'b0;
    #2 nRST = 1'b0;
    step(1);
    checks++; if (nre_a !== 1'b1)    begin errors++; $display("FAIL reset_nre: got %b, required 1", nre_a); end
    checks++; if (valid_a !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b, required 0", valid_a); end
    checks++; if (data_a !== 32'd0)  begin errors++; $display("FAIL reset_data: got %0h, required 0", data_a); end
    checks++; if (last_a !== 1'b0)   begin errors++; $display("FAIL reset_last: got %b, required 0", last_a); end
    checks++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
    checks++; if (last_b !== 1'b0)   begin errors++; $display("FAIL reset_last_b: got %b, required 0", last_b); end
    checks++; if (valid_b !== 1'b0)  begin errors++; $display("FAIL reset_valid_b: got %b, required 0", valid_b); end
    nRST = 1'b1;
    step(1);
  endtask

  task automatic test_stream;
    do_reset();
    en_a = 1'b1; ready_a = 1'b1; next_a = 0; feed_a = 5;
    wait_beats_a(5, 60, 1'b0);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stream_busy_after: got %b, required 0", busy_a); end
    for (int i = 0; i < 5 && i < bd_a.size(); i++) begin
      checks++; if (bd_a[i] !== 32'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %0d, required %0d", i, bd_a[i], i); end
      checks++; if (bl_a[i] !== (i == 3)) begin errors++; $display("FAIL stream_last[%0d]: got %b, required %b", i, bl_a[i], (i == 3)); end
    end
    if (bd_a.size() >= 5) begin
      checks++; if (bc_a[4] - bc_a[0] != 4) begin errors++; $display("FAIL stream_gap: span %0d, required 4", bc_a[4] - bc_a[0]); end
      checks++; if (bbusy_a[4] !== 1'b1) begin errors++; $display("FAIL stream_busy_last: got %b, required 1", bbusy_a[4]); end
    end
    checks++; if (first_vld_a - first_pop_a != 2) begin errors++; $display("FAIL stream_latency: got %0d, required 2", first_vld_a - first_pop_a); end
  endtask

  task automatic test_stall;
    do_reset();
    en_a = 1'b1; ready_a = 1'b0; next_a = 0; feed_a = 4;
    step(8);
    checks++; if (pops_a != 2)       begin errors++; $display("FAIL stall_pops: got %0d, required 2", pops_a); end
    checks++; if (valid_a !== 1'b1)  begin errors++; $display("FAIL stall_valid: got %b, required 1", valid_a); end
    checks++; if (data_a !== 32'd0)  begin errors++; $display("FAIL stall_hold: got %0d, required 0", data_a); end
    ready_a = 1'b1;
    wait_beats_a(4, 40, 1'b0);
    for (int i = 0; i < 4 && i < bd_a.size(); i++) begin
      checks++; if (bd_a[i] !== 32'(i)) begin errors++; $display("FAIL stall_data[%0d]: got %0d, required %0d", i, bd_a[i], i); end
    end
    if (bd_a.size() >= 4) begin
      checks++; if (bc_a[3] - bc_a[0] != 3) begin errors++; $display("FAIL stall_gap: span %0d, required 3", bc_a[3] - bc_a[0]); end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    en_a = 1'b1; ready_a = 1'b1; next_a = 0; feed_a = 8;
    wait_beats_a(8, 80, 1'b1);
    for (int i = 0; i < 8 && i < bd_a.size(); i++) begin
      checks++; if (bd_a[i] !== 32'(i)) begin errors++; $display("FAIL toggle_data[%0d]: got %0d, required %0d", i, bd_a[i], i); end
    end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL toggle_outstanding: over-limit flag %b, required 0", ovf_a); end
    ready_a = 1'b1;
  endtask

  task automatic test_en_drop;
    int k = 0;
    do_reset();
    ready_a = 1'b1; next_a = 0; feed_a = 2;
    while (fa_cnt != 2'd2 && k < 20) begin step(1); k++; end
    checks++; if (fa_cnt !== 2'd2) begin errors++; $display("FAIL en_fill: fifo count %0d, required 2", fa_cnt); end
    en_a = 1'b1;
    step(1);
    en_a = 1'b0;
    step(8);
    checks++; if (pops_a != 1)        begin errors++; $display("FAIL en_pops: got %0d, required 1", pops_a); end
    checks++; if (bd_a.size() != 1)   begin errors++; $display("FAIL en_beats: got %0d, required 1", bd_a.size()); end
    if (bd_a.size() >= 1) begin
      checks++; if (bd_a[0] !== 32'd0) begin errors++; $display("FAIL en_word: got %0d, required 0", bd_a[0]); end
    end
    checks++; if (fa_cnt !== 2'd1)    begin errors++; $display("FAIL en_fifo_left: got %0d, required 1", fa_cnt); end
    checks++; if (busy_a !== 1'b0)    begin errors++; $display("FAIL en_busy: got %b, required 0", busy_a); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    en_a = 1'b1; ready_a = 1'b1; next_a = 0; feed_a = 6;
    wait_beats_a(2, 40, 1'b0);
    ready_a = 1'b0;
    step(5);
    checks++; if (bd_a.size() != 2)  begin errors++; $display("FAIL mid_beats: got %0d, required 2", bd_a.size()); end
    checks++; if (data_a !== 32'd2)  begin errors++; $display("FAIL mid_head: got %0d, required 2", data_a); end
    nRST = 1'b0; feed_a = 0;
    #1;
    checks++; if (valid_a !== 1'b0)  begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", valid_a); end
    checks++; if (data_a !== 32'd0)  begin errors++; $display("FAIL mid_rst_data: got %0h, required 0", data_a); end
    checks++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy_a); end
    checks++; if (nre_a !== 1'b1)    begin errors++; $display("FAIL mid_rst_nre: got %b, required 1", nre_a); end
    step(1);
    checks++; if (last_a !== 1'b0)   begin errors++; $display("FAIL mid_rst_last: got %b, required 0", last_a); end
    next_a = 100; feed_a = 4; ready_a = 1'b1;
    nRST = 1'b1;
    wait_beats_a(4, 60, 1'b0);
    for (int i = 0; i < 4 && i < bd_a.size(); i++) begin
      checks++; if (bd_a[i] !== 32'(100 + i)) begin errors++; $display("FAIL mid_new_data[%0d]: got %0d, required %0d", i, bd_a[i], 100 + i); end
      checks++; if (bl_a[i] !== (i == 3)) begin errors++; $display("FAIL mid_new_last[%0d]: got %b, required %b", i, bl_a[i], (i == 3)); end
    end
  endtask

  task automatic test_fwft_burst1;
    do_reset();
    en_b = 1'b1; ready_b = 1'b1; next_b = 0; feed_b = 5;
    wait_beats_b(5, 60);
    for (int i = 0; i < 5 && i < bd_b.size(); i++) begin
      checks++; if (bd_b[i] !== 32'(i)) begin errors++; $display("FAIL fwft_data[%0d]: got %0d, required %0d", i, bd_b[i], i); end
      checks++; if (bl_b[i] !== 1'b1) begin errors++; $display("FAIL fwft_last[%0d]: got %b, required 1", i, bl_b[i]); end
    end
    checks++; if (first_vld_b - first_pop_b != 1) begin errors++; $display("FAIL fwft_latency: got %0d, required 1", first_vld_b - first_pop_b); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_fwft_burst1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
